hybrid_cache_mem_responder: RTL and testbench

Memory-side responder for the hybrid cache line's memory port. Accepts per-word read and write requests (`mem_rdreq`/`mem_wrreq`, `mem_addr`, `mem_in`) and buffers them in a request FIFO. Issues them in order to a backing RAM bus with an accept handshake, and returns read data in order on `mem_out`/`mem_out_valid`. Drives `cache_line_pause` as early backpressure. Sits between one cache line and the memory controller.

---
 rtl/hybrid_cache_mem_responder_if.sv | 36 +++
 rtl/hybrid_cache_mem_responder.sv | 92 +++++++++
 tb/tb_hybrid_cache_mem_responder.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hybrid_cache_mem_responder_if.sv
// Bus bundle for the hybrid cache line memory responder: cache-side request/response
// signals plus the backing RAM port.
interface hybrid_cache_mem_responder_if #(
    parameter int unsigned ADDRBITS = 32,
    parameter int unsigned DATABITS = 32
);
    logic [ADDRBITS-1:0] mem_addr;
    logic [DATABITS-1:0] mem_in;
    logic                mem_wrreq;
    logic                mem_rdreq;
    logic [DATABITS-1:0] mem_out;
    logic                mem_out_valid;
    logic                cache_line_pause;
    logic                ram_req;
    logic                ram_we;
    logic [ADDRBITS-1:0] ram_addr;
    logic [DATABITS-1:0] ram_wdata;
    logic                ram_ack;
    logic [DATABITS-1:0] ram_rdata;
    logic                ram_rdata_valid;
    logic                busy;
    logic                overflow_err;
    logic                protocol_err;

    modport slave (
        input  mem_addr, mem_in, mem_wrreq, mem_rdreq, ram_ack, ram_rdata, ram_rdata_valid,
        output mem_out, mem_out_valid, cache_line_pause, ram_req, ram_we, ram_addr, ram_wdata,
               busy, overflow_err, protocol_err
    );

    modport master (
        output mem_addr, mem_in, mem_wrreq, mem_rdreq, ram_ack, ram_rdata, ram_rdata_valid,
        input  mem_out, mem_out_valid, cache_line_pause, ram_req, ram_we, ram_addr, ram_wdata,
               busy, overflow_err, protocol_err
    );
endinterface

// File: rtl/hybrid_cache_mem_responder.sv
// In-order memory responder: request FIFO toward a RAM with accept handshake, read data
// returned in issue order, registered early backpressure and sticky error flags.
module hybrid_cache_mem_responder #(
    parameter int unsigned ADDRBITS     = 32,
    parameter int unsigned DATABITS     = 32,
    parameter int unsigned FIFOBITS     = 3,
    parameter int unsigned PAUSE_MARGIN = 2
) (
    input logic                          clk,
    input logic                          reset,
    hybrid_cache_mem_responder_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << FIFOBITS;

    typedef logic [FIFOBITS-1:0] ptr_t;
    typedef logic [FIFOBITS:0]   cnt_t;
    typedef logic [FIFOBITS+1:0] pend_t;

    localparam cnt_t CNT_FULL  = cnt_t'(DEPTH);
    localparam cnt_t PAUSE_LVL = cnt_t'(DEPTH - PAUSE_MARGIN);

    logic                fifo_we    [DEPTH];
    logic [ADDRBITS-1:0] fifo_addr  [DEPTH];
    logic [DATABITS-1:0] fifo_wdata [DEPTH];

    ptr_t                wr_ptr, rd_ptr;
    cnt_t                cnt, cnt_next;
    pend_t               pend, pend_next, pend_plus;
    logic [DATABITS-1:0] mem_out_r;
    logic                mem_out_valid_r, pause_r, overflow_r, protocol_r;
    logic                req_any, pop, push, pop_rd, rsp_ok, unsolicited;
    logic                overflow_set, protocol_set;

    always_comb begin
        req_any      = bus.mem_wrreq | bus.mem_rdreq;
        pop          = (cnt != '0) && bus.ram_ack;
        // A full FIFO still takes a request when the head leaves in the same cycle.
        push         = req_any && ((cnt != CNT_FULL) || pop);
        overflow_set = req_any && !push;
        pop_rd       = pop && !fifo_we[rd_ptr];
        pend_plus    = pend + pend_t'(pop_rd);
        unsolicited  = bus.ram_rdata_valid && (pend_plus == '0);
        rsp_ok       = bus.ram_rdata_valid && !unsolicited;
        protocol_set = (bus.mem_wrreq && bus.mem_rdreq) || unsolicited;
        pend_next    = pend_plus - pend_t'(rsp_ok);
        cnt_next     = cnt + cnt_t'(push) - cnt_t'(pop);
    end

    // Storage carries no reset; validity is tracked by cnt and the pointers.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_we[wr_ptr]    <= bus.mem_wrreq;
            fifo_addr[wr_ptr]  <= bus.mem_addr;
            fifo_wdata[wr_ptr] <= bus.mem_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            cnt             <= '0;
            pend            <= '0;
            mem_out_r       <= '0;
            mem_out_valid_r <= 1'b0;
            pause_r         <= 1'b0;
            overflow_r      <= 1'b0;
            protocol_r      <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ptr_t'(1);
            if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
            cnt             <= cnt_next;
            pend            <= pend_next;
            mem_out_valid_r <= rsp_ok;
            if (rsp_ok) mem_out_r <= bus.ram_rdata;
            pause_r         <= (cnt_next >= PAUSE_LVL);
            overflow_r      <= overflow_r | overflow_set;
            protocol_r      <= protocol_r | protocol_set;
        end
    end

    assign bus.ram_req          = (cnt != '0);
    assign bus.ram_we           = bus.ram_req && fifo_we[rd_ptr];
    assign bus.ram_addr         = fifo_addr[rd_ptr];
    assign bus.ram_wdata        = fifo_wdata[rd_ptr];
    assign bus.mem_out          = mem_out_r;
    assign bus.mem_out_valid    = mem_out_valid_r;
    assign bus.cache_line_pause = pause_r;
    assign bus.busy             = (cnt != '0) || (pend != '0);
    assign bus.overflow_err     = overflow_r;
    assign bus.protocol_err     = protocol_r;
endmodule

// File: tb/tb_hybrid_cache_mem_responder.sv
// Bench for hybrid_cache_mem_responder: directed scenarios plus random traffic against a
// queue-based reference model and a latency-modelled RAM.
module tb_hybrid_cache_mem_responder;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int FB = 3;
    localparam int PM = 2;
    localparam int D  = 1 << FB;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } ret_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hybrid_cache_mem_responder_if #(.ADDRBITS(AW), .DATABITS(DW)) bus ();

    hybrid_cache_mem_responder #(
        .ADDRBITS(AW), .DATABITS(DW), .FIFOBITS(FB), .PAUSE_MARGIN(PM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model state
    req_t          mq[$];
    logic [DW-1:0] exp_rd[$];
    logic [DW-1:0] ref_mem[logic [AW-1:0]];
    int            m_pend;
    logic          m_ovf, m_proto, m_mov, m_pause;
    logic [DW-1:0] m_mout;

    // RAM environment state
    logic [DW-1:0] env_mem[logic [AW-1:0]];
    ret_t          pipe[$];
    int            lat, last_due, cyc;
    logic          inject;

    int compared, mismatched, mov_count;

    function automatic logic [DW-1:0] mem_default(input logic [AW-1:0] a);
        return 32'hDEAD0000 ^ a;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_step();
        req_t h;
        bit   pop, can_push, pop_rd;
        int   pend_plus;
        h = '{we: 1'b0, addr: '0, wdata: '0};
        if (reset) begin
            mq.delete();
            exp_rd.delete();
            m_pend = 0; m_ovf = 0; m_proto = 0; m_mov = 0; m_pause = 0; m_mout = '0;
            return;
        end
        pop      = (mq.size() != 0) && bus.ram_ack;
        can_push = (mq.size() < D) || pop;
        pop_rd   = 0;
        if (pop) begin
            h = mq.pop_front();
            if (h.we) ref_mem[h.addr] = h.wdata;
            else begin
                pop_rd = 1;
                exp_rd.push_back(ref_mem.exists(h.addr) ? ref_mem[h.addr] : mem_default(h.addr));
            end
        end
        if (bus.mem_wrreq || bus.mem_rdreq) begin
            if (can_push) mq.push_back('{we: bus.mem_wrreq, addr: bus.mem_addr, wdata: bus.mem_in});
            else m_ovf = 1;
        end
        if (bus.mem_wrreq && bus.mem_rdreq) m_proto = 1;
        pend_plus = m_pend + (pop_rd ? 1 : 0);
        m_mov = 0;
        if (bus.ram_rdata_valid) begin
            if (pend_plus == 0) begin
                m_proto = 1;
                m_pend  = 0;
            end else begin
                m_pend = pend_plus - 1;
                m_mov  = 1;
                m_mout = exp_rd.pop_front();
            end
        end else begin
            m_pend = pend_plus;
        end
        m_pause = (mq.size() >= D - PM);
    endtask

    task automatic check_all();
        bit ne;
        ne = (mq.size() != 0);
        chk1("ram_req", bus.ram_req, ne);
        chk1("ram_we", bus.ram_we, ne && mq[0].we);
        if (ne) chk32("ram_addr", bus.ram_addr, mq[0].addr);
        if (ne && mq[0].we) chk32("ram_wdata", bus.ram_wdata, mq[0].wdata);
        chk1("busy", bus.busy, ne || (m_pend != 0));
        chk1("pause", bus.cache_line_pause, m_pause);
        chk1("overflow_err", bus.overflow_err, m_ovf);
        chk1("protocol_err", bus.protocol_err, m_proto);
        chk1("mem_out_valid", bus.mem_out_valid, m_mov);
        chk32("mem_out", bus.mem_out, m_mout);
        if (bus.mem_out_valid === 1'b1) mov_count++;
    endtask

    // One clock: RAM environment drives its inputs, model advances, DUT is checked at edge+1.
    task automatic cycle();
        bit            acc, acc_we;
        logic [AW-1:0] acc_addr;
        logic [DW-1:0] acc_wd;
        int            due;
        ret_t          r;
        bus.ram_rdata_valid = 1'b0;
        bus.ram_rdata       = '0;
        if (pipe.size() != 0 && pipe[0].due <= cyc) begin
            r = pipe.pop_front();
            bus.ram_rdata_valid = 1'b1;
            bus.ram_rdata       = r.data;
        end else if (inject) begin
            bus.ram_rdata_valid = 1'b1;
            bus.ram_rdata       = $urandom;
        end
        acc      = !reset && (bus.ram_req === 1'b1) && bus.ram_ack;
        acc_we   = bus.ram_we;
        acc_addr = bus.ram_addr;
        acc_wd   = bus.ram_wdata;
        model_step();
        @(posedge clk);
        if (acc) begin
            if (acc_we) env_mem[acc_addr] = acc_wd;
            else begin
                due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                last_due = due;
                pipe.push_back('{due: due,
                    data: env_mem.exists(acc_addr) ? env_mem[acc_addr] : mem_default(acc_addr)});
            end
        end
        #1;
        cyc++;
        check_all();
    endtask

    task automatic idle_inputs();
        bus.mem_wrreq = 1'b0;
        bus.mem_rdreq = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_in    = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        idle_inputs();
        bus.ram_ack = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            if (mq.size() == 0 && m_pend == 0 && pipe.size() == 0) break;
            cycle();
        end
        chk1("drain_busy", bus.busy, 1'b0);
    endtask

    task automatic push_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.mem_wrreq = 1'b1;
        bus.mem_rdreq = 1'b0;
        bus.mem_addr  = a;
        bus.mem_in    = d;
        cycle();
    endtask

    task automatic push_read(input logic [AW-1:0] a);
        bus.mem_wrreq = 1'b0;
        bus.mem_rdreq = 1'b1;
        bus.mem_addr  = a;
        bus.mem_in    = '0;
        cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        compared = 0; mismatched = 0; mov_count = 0;
        cyc = 0; lat = 3; last_due = -1; inject = 1'b0;
        m_pend = 0; m_ovf = 0; m_proto = 0; m_mov = 0; m_pause = 0; m_mout = '0;
        idle_inputs();
        bus.ram_ack = 1'b1;
        bus.ram_rdata_valid = 1'b0;
        bus.ram_rdata = '0;
        reset = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;

        // Write-then-read, 3-cycle RAM, ack held high
        mov_count = 0;
        for (int i = 0; i < 32; i++) push_write(32'h1000 + 4 * i, 32'hA500_0000 + i);
        for (int i = 0; i < 32; i++) push_read(32'h1000 + 4 * i);
        drain(100);
        chk32("wr_rd_valid_count", mov_count, 32);

        // Full FIFO with simultaneous push and pop
        do_reset();
        bus.ram_ack = 1'b0;
        for (int i = 0; i < D; i++) push_write(32'h3000 + 4 * i, $urandom);
        bus.ram_ack = 1'b1;
        push_write(32'h3100, 32'h1234_5678);
        chk1("full_pushpop_ovf", bus.overflow_err, 1'b0);
        chk1("full_pushpop_pause", bus.cache_line_pause, 1'b1);
        drain(50);

        // Backpressure and overflow
        do_reset();
        bus.ram_ack = 1'b0;
        for (int i = 0; i < D; i++) begin
            push_write(32'h4000 + 4 * i, $urandom);
            if (i == 4) chk1("pause_after_5", bus.cache_line_pause, 1'b0);
            if (i == 5) chk1("pause_after_6", bus.cache_line_pause, 1'b1);
        end
        push_write(32'h4100, 32'hBAD0_0009);
        chk1("overflow_9th", bus.overflow_err, 1'b1);
        drain(50);

        // Simultaneous read and write
        do_reset();
        bus.ram_ack = 1'b0;
        bus.mem_wrreq = 1'b1;
        bus.mem_rdreq = 1'b1;
        bus.mem_addr  = 32'h5000;
        bus.mem_in    = 32'h0055_AA00;
        cycle();
        chk1("dual_req_we", bus.ram_we, 1'b1);
        chk1("dual_req_proto", bus.protocol_err, 1'b1);
        drain(20);

        // Unsolicited read data
        do_reset();
        inject = 1'b1;
        cycle();
        inject = 1'b0;
        cycle();
        chk1("unsol_proto", bus.protocol_err, 1'b1);
        chk1("unsol_no_valid", bus.mem_out_valid, 1'b0);

        // Reset with reads outstanding; their data arrives late
        do_reset();
        lat = 8;
        bus.ram_ack = 1'b1;
        for (int i = 0; i < 4; i++) push_read(32'h1000 + 4 * i);
        idle_inputs();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk1("midrst_busy", bus.busy, 1'b0);
        chk1("midrst_ram_req", bus.ram_req, 1'b0);
        mov_count = 0;
        repeat (12) cycle();
        chk1("midrst_late_proto", bus.protocol_err, 1'b1);
        chk32("midrst_no_valid", mov_count, 0);

        // Random traffic: well-drained phase, then heavy backpressure
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 99);
            lat = $urandom_range(1, 5);
            bus.ram_ack   = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) < 4);
            bus.mem_wrreq = (r < 40) || (r == 99);
            bus.mem_rdreq = (r >= 40 && r < 80) || (r == 99);
            bus.mem_addr  = 32'h2000 + 4 * $urandom_range(0, 15);
            bus.mem_in    = $urandom;
            cycle();
        end
        drain(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
